// File: rtl/popcnt_sched.sv
// rtl/popcnt_sched.sv - two-requester round-robin popcount engine with early termination
module popcnt_sched #(
  parameter  int N  = 20,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [N-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [N-1:0]  req1_data,
  output logic          req1_ready,
  input  logic [CW-1:0] thresh,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count,
  output logic          res_id,
  output logic          res_ge,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] thr_q, thr_d;
  logic          id_q, id_d;
  logic          last_q, last_d;
  logic          grant0, grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      thr_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_q);
    grant1 = req1_valid & (~req0_valid | ~last_q);
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    thr_d      = thr_q;
    id_d       = id_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) begin
          shift_d = grant1 ? req1_data : req0_data;
          cnt_d   = '0;
          thr_d   = thresh;
          id_d    = grant1;
          last_d  = grant1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Stop as soon as no set bits remain rather than walking all N bits.
        if (shift_q != '0) begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, shift_q[0]};
          shift_d = shift_q >> 1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    res_count = res_valid ? cnt_q : '0;
    res_id    = res_valid & id_q;
    res_ge    = res_valid & (cnt_q >= thr_q);
  end

endmodule

// File: tb/tb_popcnt_sched.sv
// tb/tb_popcnt_sched.sv - self-checking bench for popcnt_sched
module tb_popcnt_sched;
  localparam int N  = 20;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [N-1:0]  req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic [CW-1:0] thresh;
  logic          res_valid, res_ready;
  logic [CW-1:0] res_count;
  logic          res_id, res_ge, busy;

  int checks = 0;
  int passes = 0;

  popcnt_sched #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .thresh(thresh), .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_id(res_id), .res_ge(res_ge), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           req;
    logic [N-1:0] data;
    int           thr;
    int           hold;
    int           exp_cnt;
    int           exp_ge;
    int           exp_lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Reference: ones count and cycles from accept to res_valid, from the bit pattern alone.
  function automatic int ref_cnt(input logic [N-1:0] d);
    return $countones(d);
  endfunction

  function automatic int ref_lat(input logic [N-1:0] d);
    int k = -1;
    for (int i = 0; i < N; i++) if (d[i]) k = i;
    return (k < 0) ? 2 : k + 3;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    if (v.req == 0) begin req0_valid = 1'b1; req0_data = v.data; end
    else            begin req1_valid = 1'b1; req1_data = v.data; end
    thresh = CW'(v.thr);
    #1;
    chk({tag, "_ready"}, (v.req == 0) ? int'(req0_ready) : int'(req1_ready), 1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = N'($urandom); req1_data = N'($urandom);
    lat = 1;
    while (!res_valid && lat < 60) begin
      thresh = CW'($urandom_range(0, N));
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, v.exp_lat);
    for (int h = 0; h <= v.hold; h++) begin
      chk({tag, "_valid"}, int'(res_valid), 1);
      chk({tag, "_count"}, int'(res_count), v.exp_cnt);
      chk({tag, "_id"}, int'(res_id), v.req);
      chk({tag, "_ge"}, int'(res_ge), v.exp_ge);
      if (h < v.hold) begin
        thresh = CW'($urandom_range(0, N));
        @(negedge clk);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_drop_valid"}, int'(res_valid), 0);
    chk({tag, "_drop_count"}, int'(res_count), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  vec_t vecs[6];

  initial begin
    vec_t v;
    int   seen, bound;
    int   order[4];

    vecs[0] = '{0, 20'h0000B, 3,  0, 3,  1, 6};
    vecs[1] = '{1, 20'h00000, 0,  0, 0,  1, 2};
    vecs[2] = '{0, 20'hFFFFF, 20, 5, 20, 1, 22};
    vecs[3] = '{1, 20'h00007, 4,  0, 3,  0, 5};
    vecs[4] = '{0, 20'h80000, 1,  2, 1,  1, 22};
    vecs[5] = '{1, 20'h00001, 2,  0, 1,  0, 3};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; thresh = '0; res_ready = 1'b0;
    #2;
    chk("reset_valid", int'(res_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_count", int'(res_count), 0);
    chk("reset_id_ge", int'({res_id, res_ge}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      v.req  = $urandom_range(0, 1);
      v.data = N'($urandom >> $urandom_range(0, 31));
      v.thr  = $urandom_range(0, N);
      v.hold = $urandom_range(0, 2);
      v.exp_cnt = ref_cnt(v.data);
      v.exp_ge  = (v.exp_cnt >= v.thr) ? 1 : 0;
      v.exp_lat = ref_lat(v.data);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Round robin with both requesters permanently valid.
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 20'h3; req1_data = 20'h5; thresh = 5'd1; res_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      bound = 0;
      #1;
      while (!(req0_ready || req1_ready) && bound < 40) begin
        chk("rr_busy_both_ready", int'(req0_ready & req1_ready), 0);
        @(negedge clk); #1;
        bound++;
      end
      chk("rr_both_ready", int'(req0_ready & req1_ready), 0);
      order[t] = req1_ready ? 1 : 0;
      chk($sformatf("rr_grant%0d", t), order[t], t % 2);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    bound = 0;
    while (busy && bound < 40) begin @(negedge clk); bound++; end
    chk("rr_drain", int'(busy), 0);
    res_ready = 1'b0;

    // Asynchronous reset while counting discards the operation.
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 20'hFFFFF; thresh = 5'd3;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(res_valid), 0);
    chk("arst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid || busy) seen++;
    end
    chk("arst_no_result", seen, 0);
    req1_valid = 1'b1; req1_data = 20'h0; thresh = 5'd0;
    #1;
    chk("post_reset_ready", int'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 1'b0;
    chk("post_reset_accept", int'(busy), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
